// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A flush or a stall loads a zeroed bubble. A stall also holds PC and IF/ID upstream.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    rd1_d,
  input  logic [DW-1:0]    rd2_d,
  input  logic [DW-1:0]    imm_d,
  input  logic [DW-1:0]    pc4_d,
  input  logic [AW-1:0]    rs_d,
  input  logic [AW-1:0]    rt_d,
  input  logic [AW-1:0]    rd_d,
  input  logic             uses_rt_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             memread_d,
  input  logic             branch_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic [CW-1:0]    aluctrl_d,
  input  logic             flush_d,
  output logic [DW-1:0]    rd1_e,
  output logic [DW-1:0]    rd2_e,
  output logic [DW-1:0]    imm_e,
  output logic [DW-1:0]    pc4_e,
  output logic [AW-1:0]    rs_e,
  output logic [AW-1:0]    rt_e,
  output logic [AW-1:0]    rd_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic             memread_e,
  output logic             branch_e,
  output logic             alusrc_e,
  output logic             regdst_e,
  output logic [CW-1:0]    aluctrl_e,
  output logic             valid_e,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic rs_match;
  logic rt_match;
  logic hazard;
  logic bubble;

  // A load to r0 never produces a dependency, so it can never stall.
  always_comb begin
    rs_match = (rt_e == rs_d);
    rt_match = uses_rt_d & (rt_e == rt_d);
    hazard   = memread_e & valid_e & (rt_e != '0) & (rs_match | rt_match);
    stall    = hazard & ~flush_d;
    bubble   = flush_d | stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      pc4_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0;
      memread_e  <= 1'b0;
      branch_e   <= 1'b0;
      alusrc_e   <= 1'b0;
      regdst_e   <= 1'b0;
      aluctrl_e  <= '0;
      valid_e    <= 1'b0;
    end else if (bubble) begin
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      pc4_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0;
      memread_e  <= 1'b0;
      branch_e   <= 1'b0;
      alusrc_e   <= 1'b0;
      regdst_e   <= 1'b0;
      aluctrl_e  <= '0;
      valid_e    <= 1'b0;
    end else begin
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      imm_e      <= imm_d;
      pc4_e      <= pc4_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      rd_e       <= rd_d;
      regwrite_e <= regwrite_d;
      memtoreg_e <= memtoreg_d;
      memwrite_e <= memwrite_d;
      memread_e  <= memread_d;
      branch_e   <= branch_d;
      alusrc_e   <= alusrc_d;
      regdst_e   <= regdst_d;
      aluctrl_e  <= aluctrl_d;
      valid_e    <= 1'b1;
    end
  end

  // Saturating stall counter, which holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model pushes expected EX state to a
// queue on every drive, and the queue is popped and compared after each posedge.
module tb_id_ex_stage;

  // Narrow counter keeps the saturation run short; behaviour is width-independent.
  localparam int TW = 6;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        memread;
    logic        branch;
    logic        alusrc;
    logic        regdst;
    logic [3:0]  aluctrl;
  } fields_t;

  typedef struct packed {
    fields_t       f;
    logic          valid;
    logic [TW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fields_t id;
  logic uses_rt = 1'b0;
  logic flush = 1'b0;

  fields_t obs;
  logic valid_e;
  logic stall;
  logic [TW-1:0] stall_cnt;

  fields_t model_ex;
  logic model_valid;
  logic [TW-1:0] model_cnt;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .AW(5), .CW(4), .CNT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd1_d(id.rd1), .rd2_d(id.rd2), .imm_d(id.imm), .pc4_d(id.pc4),
    .rs_d(id.rs), .rt_d(id.rt), .rd_d(id.rd), .uses_rt_d(uses_rt),
    .regwrite_d(id.regwrite), .memtoreg_d(id.memtoreg), .memwrite_d(id.memwrite),
    .memread_d(id.memread), .branch_d(id.branch), .alusrc_d(id.alusrc),
    .regdst_d(id.regdst), .aluctrl_d(id.aluctrl), .flush_d(flush),
    .rd1_e(obs.rd1), .rd2_e(obs.rd2), .imm_e(obs.imm), .pc4_e(obs.pc4),
    .rs_e(obs.rs), .rt_e(obs.rt), .rd_e(obs.rd),
    .regwrite_e(obs.regwrite), .memtoreg_e(obs.memtoreg), .memwrite_e(obs.memwrite),
    .memread_e(obs.memread), .branch_e(obs.branch), .alusrc_e(obs.alusrc),
    .regdst_e(obs.regdst), .aluctrl_e(obs.aluctrl),
    .valid_e(valid_e), .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic fields_t instr(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic memread, input logic regwrite);
    fields_t f;
    f          = '0;
    f.rd1      = $urandom;
    f.rd2      = $urandom;
    f.imm      = $urandom;
    f.pc4      = $urandom;
    f.rs       = rs;
    f.rt       = rt;
    f.rd       = 5'($urandom_range(1, 31));
    f.regwrite = regwrite;
    f.memtoreg = memread;
    f.memwrite = 1'b0;
    f.memread  = memread;
    f.branch   = 1'($urandom);
    f.alusrc   = 1'($urandom);
    f.regdst   = 1'($urandom);
    f.aluctrl  = 4'($urandom);
    return f;
  endfunction

  task automatic modelReset();
    model_ex    = '0;
    model_valid = 1'b0;
    model_cnt   = '0;
    sb.delete();
  endtask

  // Drive one ID instruction, check STALL before the edge, then the EX state after it.
  task automatic applyStimulus(input string tag, input fields_t f, input logic u, input logic fl);
    logic hz;
    logic exp_stall;
    exp_t e;
    exp_t got;
    id      = f;
    uses_rt = u;
    flush   = fl;
    hz = model_ex.memread & model_valid & (model_ex.rt != 5'd0) &
         ((model_ex.rt == f.rs) | (u & (model_ex.rt == f.rt)));
    exp_stall = hz & ~fl;
    #1;
    check({tag, ".stall"}, 256'(stall), 256'(exp_stall));
    if (fl | exp_stall) begin
      model_ex    = '0;
      model_valid = 1'b0;
    end else begin
      model_ex    = f;
      model_valid = 1'b1;
    end
    if (exp_stall && model_cnt != '1) model_cnt = model_cnt + 1'b1;
    e.f = model_ex; e.valid = model_valid; e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".fields"}, 256'(obs), 256'(e.f));
      check({tag, ".valid"}, 256'(valid_e), 256'(e.valid));
      check({tag, ".cnt"}, 256'(stall_cnt), 256'(e.cnt));
    end
  endtask

  initial begin
    fields_t ld;
    fields_t dep;
    modelReset();
    id = '0;

    // Reset held with random inputs across several edges.
    for (int i = 0; i < 4; i++) begin
      id      = instr(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      uses_rt = 1'($urandom);
      flush   = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset.fields", 256'(obs), 256'(0));
      check("reset.valid", 256'(valid_e), 256'(0));
      check("reset.cnt", 256'(stall_cnt), 256'(0));
      check("reset.stall", 256'(stall), 256'(0));
    end
    rst_n = 1'b1;
    flush = 1'b0;

    dep = '0;
    dep.rd1 = 32'h12345678; dep.aluctrl = 4'h2; dep.regwrite = 1'b1;
    applyStimulus("first", dep, 1'b0, 1'b0);

    // Load-use on RS: stall, bubble, then the held instruction advances.
    ld  = instr(5'd1, 5'd5, 1'b1, 1'b1);
    dep = instr(5'd5, 5'd2, 1'b0, 1'b1);
    applyStimulus("rs.load", ld, 1'b0, 1'b0);
    applyStimulus("rs.stall", dep, 1'b0, 1'b0);
    applyStimulus("rs.advance", dep, 1'b0, 1'b0);

    // RT dependence only counts when the ID instruction reads RT.
    ld  = instr(5'd1, 5'd7, 1'b1, 1'b1);
    dep = instr(5'd3, 5'd7, 1'b0, 1'b1);
    applyStimulus("rt.load0", ld, 1'b0, 1'b0);
    applyStimulus("rt.nouse", dep, 1'b0, 1'b0);
    applyStimulus("rt.load1", ld, 1'b0, 1'b0);
    applyStimulus("rt.use", dep, 1'b1, 1'b0);
    applyStimulus("rt.advance", dep, 1'b1, 1'b0);

    ld  = instr(5'd4, 5'd0, 1'b1, 1'b1);
    dep = instr(5'd0, 5'd0, 1'b0, 1'b1);
    applyStimulus("r0.load", ld, 1'b0, 1'b0);
    applyStimulus("r0.dep", dep, 1'b1, 1'b0);

    // Flush beats a simultaneous hazard.
    ld  = instr(5'd2, 5'd9, 1'b1, 1'b1);
    dep = instr(5'd9, 5'd9, 1'b0, 1'b1);
    applyStimulus("flush.load", ld, 1'b0, 1'b0);
    applyStimulus("flush.hazard", dep, 1'b1, 1'b1);

    for (int i = 0; i < (1 << TW) + 3; i++) begin
      ld  = instr(5'd6, 5'd3, 1'b1, 1'b1);
      dep = instr(5'd3, 5'd8, 1'b0, 1'b1);
      applyStimulus("sat.load", ld, 1'b0, 1'b0);
      applyStimulus("sat.dep", dep, 1'b0, 1'b0);
    end
    check("sat.final", 256'(stall_cnt), 256'({TW{1'b1}}));

    // Build STALL_CNT=9 with VALID_E=1, then drop reset between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      ld  = instr(5'd1, 5'd12, 1'b1, 1'b1);
      dep = instr(5'd12, 5'd1, 1'b0, 1'b1);
      applyStimulus("pre.load", ld, 1'b0, 1'b0);
      applyStimulus("pre.dep", dep, 1'b0, 1'b0);
    end
    applyStimulus("pre.valid", dep, 1'b0, 1'b0);
    check("pre.cnt9", 256'(stall_cnt), 256'(9));
    #2;
    rst_n = 1'b0;
    #1;
    check("async.fields", 256'(obs), 256'(0));
    check("async.valid", 256'(valid_e), 256'(0));
    check("async.cnt", 256'(stall_cnt), 256'(0));
    check("async.stall", 256'(stall), 256'(0));
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release.valid", 256'(valid_e), 256'(0));
    @(posedge clk);
    #1;
    applyStimulus("release.step", instr(5'd3, 5'd4, 1'b0, 1'b1), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
